// File: rtl/duty_ramp_pkg.sv
// Shared types and helpers for the breathing-LED duty ramp.
// The state encoding is also the value presented on the phase output.
package duty_ramp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RISE    = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_FALL    = 3'd3,
        ST_HOLD_LO = 3'd4
    } ramp_state_e;

    localparam int unsigned DUTY_W = 32;

    function automatic logic [DUTY_W-1:0] min_u32(input logic [DUTY_W-1:0] a,
                                                  input logic [DUTY_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // The sum is widened to 33 bits so a large step cannot wrap before the clamp.
    function automatic logic [DUTY_W-1:0] step_up(input logic [DUTY_W-1:0] cur,
                                                  input logic [DUTY_W-1:0] step,
                                                  input logic [DUTY_W-1:0] peak);
        logic [DUTY_W:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        return (sum > {1'b0, peak}) ? peak : sum[DUTY_W-1:0];
    endfunction

    function automatic logic [DUTY_W-1:0] step_down(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] step);
        return (cur <= step) ? 32'd0 : (cur - step);
    endfunction

endpackage

// File: rtl/duty_ramp_frame_timer.sv
// PWM frame timer: counts 0..PERIOD-1 while enabled and flags the last clock
// of each frame with a registered tick.
module frame_timer #(
    parameter int unsigned PERIOD = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [31:0] LAST = 32'(PERIOD - 1);

    logic [31:0] count_r;
    logic        tick_r;

    // Frame counter; tick_r is high exactly while count_r sits at LAST.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            count_r <= 32'd0;
            tick_r  <= 1'b0;
        end else if (count_r == LAST) begin
            count_r <= 32'd0;
            tick_r  <= 1'b0;
        end else begin
            count_r <= count_r + 32'd1;
            tick_r  <= ((count_r + 32'd1) == LAST);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/duty_ramp.sv
// Breathing duty ramp: rises to a sampled peak, dwells, falls to zero, dwells,
// and repeats, changing duty only at PWM frame boundaries.
module duty_ramp
    import duty_ramp_pkg::*;
#(
    parameter int unsigned PERIOD       = 1000,
    parameter int unsigned DUTY_STEP    = 10,
    parameter int unsigned STEP_PERIODS = 1,
    parameter int unsigned HOLD_PERIODS = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] max_duty,
    output logic [31:0] duty,
    output logic [31:0] period,
    output logic        frame_tick,
    output logic [2:0]  phase,
    output logic        cycle_done
);

    localparam logic [31:0] PERIOD_C  = 32'(PERIOD);
    localparam logic [31:0] STEP_C    = 32'(DUTY_STEP);
    localparam logic [31:0] STEP_LAST = 32'(STEP_PERIODS - 1);
    localparam logic [31:0] HOLD_LAST = 32'(HOLD_PERIODS - 1);

    ramp_state_e state_r;
    logic [31:0] duty_r;
    logic [31:0] peak_r;
    logic [31:0] step_cnt_r;
    logic [31:0] hold_cnt_r;
    logic        tick_s;
    logic        step_last_s;
    logic        hold_last_s;
    logic [31:0] duty_up_s;
    logic [31:0] duty_dn_s;

    frame_timer #(
        .PERIOD (PERIOD)
    ) u_frame_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick_s)
    );

    assign step_last_s = (step_cnt_r == STEP_LAST);
    assign hold_last_s = (hold_cnt_r == HOLD_LAST);
    assign duty_up_s   = step_up(duty_r, STEP_C, peak_r);
    assign duty_dn_s   = step_down(duty_r, STEP_C);

    // Breathing state machine; every change besides en-drop/reset waits for a frame tick.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state_r    <= ST_IDLE;
            duty_r     <= 32'd0;
            peak_r     <= 32'd0;
            step_cnt_r <= 32'd0;
            hold_cnt_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r    <= ST_RISE;
                    peak_r     <= min_u32(max_duty, PERIOD_C);
                    duty_r     <= 32'd0;
                    step_cnt_r <= 32'd0;
                    hold_cnt_r <= 32'd0;
                end
                ST_RISE: begin
                    if (tick_s) begin
                        if (step_last_s) begin
                            step_cnt_r <= 32'd0;
                            duty_r     <= duty_up_s;
                            if (duty_up_s == peak_r) begin
                                state_r    <= ST_HOLD_HI;
                                hold_cnt_r <= 32'd0;
                            end
                        end else begin
                            step_cnt_r <= step_cnt_r + 32'd1;
                        end
                    end
                end
                ST_HOLD_HI: begin
                    if (tick_s) begin
                        if (hold_last_s) begin
                            state_r    <= ST_FALL;
                            hold_cnt_r <= 32'd0;
                            step_cnt_r <= 32'd0;
                        end else begin
                            hold_cnt_r <= hold_cnt_r + 32'd1;
                        end
                    end
                end
                ST_FALL: begin
                    if (tick_s) begin
                        if (step_last_s) begin
                            step_cnt_r <= 32'd0;
                            duty_r     <= duty_dn_s;
                            if (duty_dn_s == 32'd0) begin
                                state_r    <= ST_HOLD_LO;
                                hold_cnt_r <= 32'd0;
                            end
                        end else begin
                            step_cnt_r <= step_cnt_r + 32'd1;
                        end
                    end
                end
                ST_HOLD_LO: begin
                    if (tick_s) begin
                        if (hold_last_s) begin
                            state_r    <= ST_RISE;
                            peak_r     <= min_u32(max_duty, PERIOD_C);
                            hold_cnt_r <= 32'd0;
                            step_cnt_r <= 32'd0;
                        end else begin
                            hold_cnt_r <= hold_cnt_r + 32'd1;
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    duty_r     <= 32'd0;
                    step_cnt_r <= 32'd0;
                    hold_cnt_r <= 32'd0;
                end
            endcase
        end
    end

    // Built only from registers so the pulse lines up with the final HOLD_LO tick.
    assign cycle_done = tick_s && (state_r == ST_HOLD_LO) && hold_last_s;
    assign frame_tick = tick_s;
    assign duty       = duty_r;
    assign phase      = state_r;
    assign period     = PERIOD_C;

endmodule

// File: tb/tb_duty_ramp.sv
// Self-checking bench for duty_ramp: a frame-level breath-profile model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_duty_ramp;

    localparam int P = 10;
    localparam int D = 3;
    localparam int S = 1;
    localparam int H = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [31:0] max_duty = 32'd0;
    logic [31:0] duty;
    logic [31:0] period;
    logic        frame_tick;
    logic [2:0]  phase;
    logic        cycle_done;

    always #5 clk = ~clk;

    duty_ramp #(
        .PERIOD       (P),
        .DUTY_STEP    (D),
        .STEP_PERIODS (S),
        .HOLD_PERIODS (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .max_duty   (max_duty),
        .duty       (duty),
        .period     (period),
        .frame_tick (frame_tick),
        .phase      (phase),
        .cycle_done (cycle_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: one breath is precomputed as per-frame (phase, duty) lists.
    bit     m_active = 1'b0;
    bit     m_kill   = 1'b0;
    int     k        = 0;
    int     base     = 0;
    int     prof_ph[$];
    longint prof_du[$];
    int     cd_count = 0;
    longint max_seen = 0;
    longint prev_duty = 0;
    bit     prev_tick = 1'b0;
    bit     have_prev = 1'b0;

    task automatic check_eq(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint clamp_peak(input longint md);
        return (md < P) ? md : P;
    endfunction

    task automatic build(input longint pk);
        int nsteps;
        longint v;
        prof_ph.delete();
        prof_du.delete();
        nsteps = (pk == 0) ? 1 : int'((pk + D - 1) / D);
        for (int f = 0; f < S * nsteps; f++) begin
            v = longint'((f / S) * D);
            prof_ph.push_back(1);
            prof_du.push_back((v < pk) ? v : pk);
        end
        for (int f = 0; f < H; f++) begin
            prof_ph.push_back(2);
            prof_du.push_back(pk);
        end
        for (int f = 0; f < S * nsteps; f++) begin
            v = pk - longint'((f / S) * D);
            prof_ph.push_back(3);
            prof_du.push_back((v < 0) ? 0 : v);
        end
        for (int f = 0; f < H; f++) begin
            prof_ph.push_back(4);
            prof_du.push_back(0);
        end
    endtask

    function automatic bit exp_tick();
        return m_active && ((k % P) == P - 1);
    endfunction

    function automatic bit exp_done();
        return exp_tick() && ((k / P - base) == prof_ph.size() - 1);
    endfunction

    task automatic model_edge();
        m_kill = rst || !en;
        if (m_kill) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1;
            k = 1;
            base = 0;
            build(clamp_peak(longint'(max_duty)));
        end else begin
            if (exp_done()) begin
                base = base + prof_ph.size();
                build(clamp_peak(longint'(max_duty)));
            end
            k++;
        end
    endtask

    task automatic compare();
        int fr;
        longint e_ph;
        longint e_du;
        fr = k / P - base;
        e_ph = m_active ? longint'(prof_ph[fr]) : 0;
        e_du = m_active ? prof_du[fr] : 0;
        check_eq("phase", longint'(phase), e_ph);
        check_eq("duty", longint'(duty), e_du);
        check_eq("frame_tick", longint'(frame_tick), longint'(exp_tick()));
        check_eq("cycle_done", longint'(cycle_done), longint'(exp_done()));
        check_eq("period", longint'(period), longint'(P));
        if (have_prev) begin
            n_tests++;
            if (longint'(duty) != prev_duty && !prev_tick && !m_kill) begin
                n_fail++;
                $display("FAIL duty_midframe: got %0d expected %0d", duty, prev_duty);
            end
        end
        if (cycle_done) cd_count++;
        if (longint'(duty) > max_seen) max_seen = longint'(duty);
        prev_duty = longint'(duty);
        prev_tick = frame_tick;
        have_prev = 1'b1;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            compare();
        end
    endtask

    int e33[11] = '{3, 6, 8, 8, 8, 5, 2, 0, 0, 0, 3};
    int e37[6]  = '{2, 2, 3, 4, 4, 1};

    initial begin
        cyc(3);
        check_eq("reset_duty", longint'(duty), 0);
        check_eq("reset_phase", longint'(phase), 0);
        check_eq("reset_period", longint'(period), 10);
        rst = 1'b0;
        cyc(2);

        // Basic breath with peak 8
        max_duty = 32'd8;
        en = 1'b1;
        cyc(1);
        check_eq("rise_entry", longint'(phase), 1);
        cd_count = 0;
        for (int i = 0; i < 11; i++) begin
            cyc(P);
            check_eq($sformatf("ramp_f%0d", i + 1), longint'(duty), longint'(e33[i]));
        end
        check_eq("cd_once", longint'(cd_count), 1);

        // en dropped mid-rise at duty 6
        cyc(P);
        check_eq("mid_rise_duty", longint'(duty), 6);
        en = 1'b0;
        cyc(1);
        check_eq("en_off_phase", longint'(phase), 0);
        check_eq("en_off_duty", longint'(duty), 0);
        check_eq("en_off_tick", longint'(frame_tick), 0);
        cyc(12);
        en = 1'b1;
        cyc(1);
        check_eq("en_on_phase", longint'(phase), 1);
        check_eq("en_on_duty", longint'(duty), 0);

        // reset during fall with en held high
        cyc(60);
        check_eq("fall_phase", longint'(phase), 3);
        check_eq("fall_duty", longint'(duty), 5);
        rst = 1'b1;
        cyc(1);
        check_eq("rst_phase", longint'(phase), 0);
        check_eq("rst_duty", longint'(duty), 0);
        rst = 1'b0;
        cyc(1);
        check_eq("rst_resume", longint'(phase), 1);

        // peak clamp to PERIOD, then max_duty change during HOLD_HI
        en = 1'b0;
        cyc(2);
        max_duty = 32'd5000;
        en = 1'b1;
        max_seen = 0;
        cyc(1);
        cyc(40);
        check_eq("clamp_hold_phase", longint'(phase), 2);
        check_eq("clamp_hold_duty", longint'(duty), 10);
        max_duty = 32'd4;
        cyc(30);
        check_eq("late_change_fall", longint'(duty), 7);
        cyc(70);
        check_eq("new_peak_duty", longint'(duty), 4);
        check_eq("new_peak_phase", longint'(phase), 2);
        check_eq("max_seen", max_seen, 10);

        // zero peak still walks all phases
        en = 1'b0;
        cyc(1);
        max_duty = 32'd0;
        en = 1'b1;
        cyc(1);
        cd_count = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(P);
            check_eq($sformatf("zero_phase_f%0d", i + 1), longint'(phase), longint'(e37[i]));
            check_eq($sformatf("zero_duty_f%0d", i + 1), longint'(duty), 0);
        end
        check_eq("zero_cd_once", longint'(cd_count), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/duty_ramp.md
DUTY_RAMP -- requirements
Module: duty_ramp

Interface
REQ-001 SHALL have parameter PERIOD, default 1000, PWM period in clk cycles, presented on `period`; legal range 2..2^31-1.
REQ-002 SHALL have parameter DUTY_STEP, default 10, duty increment/decrement per step; must be >=1.
REQ-003 SHALL have parameter STEP_PERIODS, default 1, number of PWM frames between duty steps; must be >=1.
REQ-004 SHALL have parameter HOLD_PERIODS, default 100, number of PWM frames to dwell at each extreme; must be >=1.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port en  input  1  breathing enable; level-sensitive.
REQ-008 SHALL have port max_duty  input  32  peak duty target in clk cycles.
REQ-009 SHALL have port duty  output  32  duty command for the downstream PWM generator; registered.
REQ-010 SHALL have port period  output  32  PWM period for the downstream generator; equal to PERIOD.
REQ-011 SHALL have port frame_tick  output  1  one-cycle pulse on the last clk of each PWM frame.
REQ-012 SHALL have port phase  output  3  current state encoding.
REQ-013 SHALL have port cycle_done  output  1  one-cycle pulse when a full breath completes.

Function
REQ-014 SHALL run a frame counter 0..PERIOD-1 while en=1, wrap to 0, and pulse frame_tick when the count equals PERIOD-1.
REQ-015 SHALL hold the frame counter at 0 and frame_tick at 0 while en=0.
REQ-016 SHALL change duty and state only on cycles with frame_tick=1, except for en-deassertion and reset, so the PWM never sees a mid-frame duty change.
REQ-017 SHALL implement states IDLE=0, RISE=1, HOLD_HI=2, FALL=3 and HOLD_LO=4, with phase reflecting the registered state.
REQ-018 SHALL go IDLE->RISE on the first clk with en=1, and sample peak = min(max_duty, PERIOD) on that clk.
REQ-019 SHALL, in RISE, on every STEP_PERIODS-th frame_tick, set duty to min(duty+DUTY_STEP, peak); on the step where duty reaches peak, go to HOLD_HI.
REQ-020 SHALL, in HOLD_HI, after HOLD_PERIODS frame_ticks, go to FALL.
REQ-021 SHALL, in FALL, on every STEP_PERIODS-th frame_tick, set duty to 0 if duty<=DUTY_STEP, otherwise duty-DUTY_STEP; on reaching 0, go to HOLD_LO.
REQ-022 SHALL, in HOLD_LO, after HOLD_PERIODS frame_ticks, pulse cycle_done coincident with that frame_tick, re-sample peak, and go to RISE.
REQ-023 SHALL, when peak=0 at RISE entry, go to HOLD_HI on the first step tick with duty remaining 0.
REQ-024 SHALL compute duty arithmetic in 33 bits so that duty+DUTY_STEP cannot wrap before the clamp.
REQ-025 SHALL, on en=0 in any state, go to IDLE on the next clk with duty=0 and all counters cleared.
REQ-026 SHALL ignore max_duty changes outside the sample points in REQ-018 and REQ-022.

Reset
REQ-027 SHALL, on rst=1 at a rising clk edge, set state=IDLE, duty=0, frame_tick=0, cycle_done=0, and clear all counters.
REQ-028 SHALL drive period=PERIOD at all times, including during reset.
REQ-029 SHALL give rst priority over en, and a mid-ramp reset SHALL resume only through IDLE->RISE.

Structure
REQ-030 SHALL take the state encoding constants from the shared package.
REQ-031 SHALL implement the frame counter as sub-module frame_timer (ports: clk, rst, en, tick; parameter PERIOD), reusable by other PWM consumers.
REQ-032 SHALL contain a step/hold counter and a state machine in the top level only, with no combinational path from inputs to outputs.

Verification
REQ-033 SHALL cover: PERIOD=10, DUTY_STEP=3, STEP_PERIODS=1, HOLD_PERIODS=2, max_duty=8 -> duty per frame 3,6,8,8,8,5,2,0,0,0,3; cycle_done pulses once at the frame where duty returns to 3's preceding tick.
REQ-034 SHALL cover: max_duty=5000 with PERIOD=10 -> peak clamps at 10, and duty never exceeds 10.
REQ-035 SHALL cover: en dropped mid-RISE at duty=6 -> next clk phase=0, duty=0, frame_tick stays 0; en re-raised -> RISE from 0.
REQ-036 SHALL cover: rst pulsed during FALL together with en=1 -> outputs reset next clk; the ramp restarts at RISE.
REQ-037 SHALL cover: max_duty=0 -> phase steps RISE->HOLD_HI->FALL->HOLD_LO while duty stays 0; cycle_done still pulses.
REQ-038 SHALL cover: max_duty changed mid-HOLD_HI -> no effect until the next RISE entry; duty changes only on frame_tick cycles, checked by assertion.
